m2vsidetx: RTL and testbench

//  Side-information sequencer. Drives the stage-0 side-info pulse protocol consumed by m2vside1.

---
 rtl/m2vsidetx.sv | 194 +++++++++++++++++++
 tb/tb_m2vsidetx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2vsidetx.sv
// m2vsidetx: side-information sequencer for m2vside1.
// Takes picture/macroblock headers over valid/ready, serialises them onto the
// shared s0_data bus as one-cycle pulses, then paces six
// pre_block_start/block_start pairs against blk_rdy.
module m2vsidetx #(
   parameter int MVH_WIDTH = 16,
   parameter int MVV_WIDTH = 15,
   parameter int MBX_WIDTH = 6,
   parameter int MBY_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pic_valid,
   output logic                 pic_ready,
   input  logic                 pic_iframe,
   input  logic                 pic_qstype,
   input  logic [1:0]           pic_dcprec,
   input  logic                 mb_valid,
   output logic                 mb_ready,
   input  logic                 mb_mv_en,
   input  logic                 mb_intra,
   input  logic [5:0]           mb_pattern,
   input  logic [MVH_WIDTH-1:0] mb_mv_h,
   input  logic [MVV_WIDTH-1:0] mb_mv_v,
   input  logic [MBX_WIDTH-1:0] mb_x,
   input  logic [MBY_WIDTH-1:0] mb_y,
   input  logic [4:0]           mb_qscode,
   input  logic                 blk_rdy,
   output logic [MVH_WIDTH-1:0] s0_data,
   output logic                 pict_valid,
   output logic                 mvec_h_valid,
   output logic                 mvec_v_valid,
   output logic                 s0_valid,
   output logic [MBX_WIDTH-1:0] s0_mb_x,
   output logic [MBY_WIDTH-1:0] s0_mb_y,
   output logic [4:0]           s0_mb_qscode,
   output logic                 pre_block_start,
   output logic                 block_start,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_PIC, S_MVH, S_MVV, S_HDR, S_WAIT, S_PRE, S_START
   } state_t;

   state_t                       state_q;
   logic [2:0]                   cnt_q;
   logic [MVH_WIDTH-1:0]         s0_data_q;
   logic                         pict_q, mvh_vld_q, mvv_vld_q, s0v_q;
   logic                         pre_q, bs_q, busy_q;
   logic [MBX_WIDTH-1:0]         mbx_q;
   logic [MBY_WIDTH-1:0]         mby_q;
   logic [4:0]                   qsc_q;

   // Header fields captured at accept; pure data, never reset.
   logic [3:0]                   pic_hdr_q;
   logic                         intra_q;
   logic [5:0]                   pat_q;
   logic signed [MVH_WIDTH-1:0]  mvh_q;
   logic signed [MVV_WIDTH-1:0]  mvv_q;

   logic idle, pic_acc, mb_acc;

   // Vertical MV is narrower than the bus; replicate its sign bit upward.
   function automatic logic [MVH_WIDTH-1:0] sext_mvv(input logic signed [MVV_WIDTH-1:0] v);
      logic signed [MVH_WIDTH-1:0] w;
      w = MVH_WIDTH'(v);
      return w;
   endfunction

   // {intra, pattern} on the low 7 bits, upper bits forced to zero.
   function automatic logic [MVH_WIDTH-1:0] pack_hdr(input logic intra, input logic [5:0] pat);
      return MVH_WIDTH'({intra, pat});
   endfunction

   assign idle    = (state_q == S_IDLE);
   assign pic_acc = idle & pic_valid;
   assign mb_acc  = idle & mb_valid & ~pic_valid;

   assign pic_ready       = idle;
   assign mb_ready        = idle & ~pic_valid;
   assign s0_data         = s0_data_q;
   assign pict_valid      = pict_q;
   assign mvec_h_valid    = mvh_vld_q;
   assign mvec_v_valid    = mvv_vld_q;
   assign s0_valid        = s0v_q;
   assign s0_mb_x         = mbx_q;
   assign s0_mb_y         = mby_q;
   assign s0_mb_qscode    = qsc_q;
   assign pre_block_start = pre_q;
   assign block_start     = bs_q;
   assign busy            = busy_q;

   // Capture header payloads on the accept edge for later serialisation.
   always_ff @(posedge clk) begin
      if (pic_acc) begin
         pic_hdr_q <= {pic_iframe, pic_qstype, pic_dcprec};
      end
      if (mb_acc) begin
         intra_q <= mb_intra;
         pat_q   <= mb_pattern;
         mvh_q   <= mb_mv_h;
         mvv_q   <= mb_mv_v;
      end
   end

   // Sequencer: state, block counter and every registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         s0_data_q <= '0;
         pict_q    <= 1'b0;
         mvh_vld_q <= 1'b0;
         mvv_vld_q <= 1'b0;
         s0v_q     <= 1'b0;
         pre_q     <= 1'b0;
         bs_q      <= 1'b0;
         busy_q    <= 1'b0;
         mbx_q     <= '0;
         mby_q     <= '0;
         qsc_q     <= '0;
      end else begin
         // Pulses and the shared bus default to quiet every cycle.
         s0_data_q <= '0;
         pict_q    <= 1'b0;
         mvh_vld_q <= 1'b0;
         mvv_vld_q <= 1'b0;
         s0v_q     <= 1'b0;
         pre_q     <= 1'b0;
         bs_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pic_valid) begin
                  state_q <= S_PIC;
                  busy_q  <= 1'b1;
               end else if (mb_valid) begin
                  state_q <= mb_mv_en ? S_MVH : S_HDR;
                  busy_q  <= 1'b1;
                  mbx_q   <= mb_x;
                  mby_q   <= mb_y;
                  qsc_q   <= mb_qscode;
               end
            end
            S_PIC: begin
               pict_q    <= 1'b1;
               s0_data_q <= MVH_WIDTH'(pic_hdr_q);
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
            end
            S_MVH: begin
               mvh_vld_q <= 1'b1;
               s0_data_q <= mvh_q;
               state_q   <= S_MVV;
            end
            S_MVV: begin
               mvv_vld_q <= 1'b1;
               s0_data_q <= sext_mvv(mvv_q);
               state_q   <= S_HDR;
            end
            S_HDR: begin
               s0v_q     <= 1'b1;
               s0_data_q <= pack_hdr(intra_q, pat_q);
               cnt_q     <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (blk_rdy) begin
                  state_q <= S_PRE;
               end
            end
            S_PRE: begin
               pre_q   <= 1'b1;
               state_q <= S_START;
            end
            S_START: begin
               bs_q <= 1'b1;
               if (cnt_q == 3'd5) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + 3'd1;
                  state_q <= S_WAIT;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m2vsidetx.sv
// Bench for m2vsidetx: a per-edge expectation timeline is built from each
// accepted header (pulse latencies, block pacing from the blk_rdy schedule)
// and every output is compared against it after every clock edge.
module tb_m2vsidetx;
   localparam int NE = 8000;

   logic        clk = 1'b0;
   logic        reset;
   logic        pic_valid, pic_ready, pic_iframe, pic_qstype;
   logic [1:0]  pic_dcprec;
   logic        mb_valid, mb_ready, mb_mv_en, mb_intra;
   logic [5:0]  mb_pattern;
   logic [15:0] mb_mv_h;
   logic [14:0] mb_mv_v;
   logic [5:0]  mb_x;
   logic [4:0]  mb_y, mb_qscode;
   logic        blk_rdy;
   logic [15:0] s0_data;
   logic        pict_valid, mvec_h_valid, mvec_v_valid, s0_valid;
   logic [5:0]  s0_mb_x;
   logic [4:0]  s0_mb_y, s0_mb_qscode;
   logic        pre_block_start, block_start, busy;

   m2vsidetx dut (
      .clk(clk), .reset(reset),
      .pic_valid(pic_valid), .pic_ready(pic_ready), .pic_iframe(pic_iframe),
      .pic_qstype(pic_qstype), .pic_dcprec(pic_dcprec),
      .mb_valid(mb_valid), .mb_ready(mb_ready), .mb_mv_en(mb_mv_en),
      .mb_intra(mb_intra), .mb_pattern(mb_pattern), .mb_mv_h(mb_mv_h),
      .mb_mv_v(mb_mv_v), .mb_x(mb_x), .mb_y(mb_y), .mb_qscode(mb_qscode),
      .blk_rdy(blk_rdy), .s0_data(s0_data), .pict_valid(pict_valid),
      .mvec_h_valid(mvec_h_valid), .mvec_v_valid(mvec_v_valid),
      .s0_valid(s0_valid), .s0_mb_x(s0_mb_x), .s0_mb_y(s0_mb_y),
      .s0_mb_qscode(s0_mb_qscode), .pre_block_start(pre_block_start),
      .block_start(block_start), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        pict, mvh, mvv, s0v, pre, bs, busy;
      bit [15:0] data;
      bit [5:0]  x;
      bit [4:0]  y, qs;
   } exp_t;

   typedef struct {
      bit        is_pic;
      bit [3:0]  pic;
      bit        mven, intra;
      bit [5:0]  pat;
      bit [15:0] mvh;
      bit [14:0] mvv;
      bit [5:0]  x;
      bit [4:0]  y, qs;
      bit [15:0] e0, e1, e2;
   } vec_t;

   exp_t ex [NE];
   bit   rdy [NE];
   vec_t tbl [8];

   int n, free_e, rst_from, rst_until;
   int checks, errs;
   int acc_pic_e, acc_mb_e;

   bit        off_pic, off_mb;
   bit [3:0]  o_pic;
   bit [15:0] o_dpic;
   bit        o_mven, o_intra;
   bit [5:0]  o_pat;
   bit [15:0] o_mvh;
   bit [14:0] o_mvv;
   bit [5:0]  o_x;
   bit [4:0]  o_y, o_qs;
   bit [15:0] o_dh, o_dv, o_ds;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s edge=%0d got=%0h want=%0h", nm, n, got, want);
      end
   endfunction

   // Expected behaviour of one macroblock accepted at edge t.
   task automatic sched_mb(int t);
      int w, p;
      for (int i = t; i < NE; i++) begin
         ex[i].x = o_x; ex[i].y = o_y; ex[i].qs = o_qs;
      end
      w = t;
      if (o_mven) begin
         ex[t+1].mvh = 1'b1; ex[t+1].data = o_dh;
         ex[t+2].mvv = 1'b1; ex[t+2].data = o_dv;
         w = t + 2;
      end
      ex[w+1].s0v = 1'b1; ex[w+1].data = o_ds;
      w = w + 1;
      for (int k = 0; k < 6; k++) begin
         p = w + 1;
         while (p < NE - 3 && !rdy[p]) p++;
         ex[p+1].pre = 1'b1;
         ex[p+2].bs  = 1'b1;
         w = p + 2;
      end
      for (int i = t; i < w; i++) ex[i].busy = 1'b1;
      free_e = w + 1;
   endtask

   // One clock: compare outputs after edge n, then drive inputs for edge n+1.
   task automatic tick();
      bit exp_idle;
      @(posedge clk);
      n++;
      #1;
      chk("pict_valid",   32'(pict_valid),      32'(ex[n].pict));
      chk("mvec_h_valid", 32'(mvec_h_valid),    32'(ex[n].mvh));
      chk("mvec_v_valid", 32'(mvec_v_valid),    32'(ex[n].mvv));
      chk("s0_valid",     32'(s0_valid),        32'(ex[n].s0v));
      chk("pre_blk",      32'(pre_block_start), 32'(ex[n].pre));
      chk("blk_start",    32'(block_start),     32'(ex[n].bs));
      chk("busy",         32'(busy),            32'(ex[n].busy));
      chk("s0_data",      32'(s0_data),         32'(ex[n].data));
      chk("s0_mb_x",      32'(s0_mb_x),         32'(ex[n].x));
      chk("s0_mb_y",      32'(s0_mb_y),         32'(ex[n].y));
      chk("s0_mb_qs",     32'(s0_mb_qscode),    32'(ex[n].qs));
      exp_idle = (n >= free_e - 1);
      chk("pic_ready",    32'(pic_ready),       32'(exp_idle));
      chk("mb_ready",     32'(mb_ready),        32'(exp_idle & ~pic_valid));
      blk_rdy    = rdy[n+1];
      pic_valid  = off_pic;
      pic_iframe = o_pic[3]; pic_qstype = o_pic[2]; pic_dcprec = o_pic[1:0];
      mb_valid   = off_mb;
      mb_mv_en = o_mven; mb_intra = o_intra; mb_pattern = o_pat;
      mb_mv_h = o_mvh; mb_mv_v = o_mvv; mb_x = o_x; mb_y = o_y; mb_qscode = o_qs;
      if (n + 1 >= rst_from && n + 1 <= rst_until) begin
         reset = 1'b1;
         for (int i = n + 1; i < NE; i++) ex[i] = '{default: 0};
         free_e = n + 2;
      end else begin
         reset = 1'b0;
         if (n + 1 >= free_e) begin
            if (off_pic) begin
               acc_pic_e = n + 1;
               ex[n+1].busy = 1'b1;
               ex[n+2].pict = 1'b1;
               ex[n+2].data = o_dpic;
               free_e = n + 3;
               off_pic = 1'b0;
            end else if (off_mb) begin
               acc_mb_e = n + 1;
               sched_mb(n + 1);
               off_mb = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_accept();
      int g = 0;
      while ((off_pic || off_mb) && g < 300) begin
         tick(); g++;
      end
      if (off_pic || off_mb) begin
         checks++; errs++;
         $display("FAIL accept_timeout edge=%0d got=pending want=accepted", n);
         off_pic = 1'b0; off_mb = 1'b0;
      end
   endtask

   task automatic drain();
      int g = 0;
      while (n + 1 < free_e && g < 400) begin
         tick(); g++;
      end
      tick();
   endtask

   task automatic load_vec(vec_t v);
      o_pic = v.pic; o_dpic = v.e0;
      o_mven = v.mven; o_intra = v.intra; o_pat = v.pat;
      o_mvh = v.mvh; o_mvv = v.mvv; o_x = v.x; o_y = v.y; o_qs = v.qs;
      o_dh = v.e0; o_dv = v.e1; o_ds = v.e2;
   endtask

   // Reference payloads computed from the field definitions.
   task automatic rand_pic();
      o_pic  = 4'($urandom);
      o_dpic = 16'(8 * o_pic[3] + 4 * o_pic[2] + o_pic[1:0]);
      off_pic = 1'b1;
   endtask

   task automatic rand_mb();
      int v;
      o_mven = 1'($urandom); o_intra = 1'($urandom); o_pat = 6'($urandom);
      o_mvh = 16'($urandom); o_mvv = 15'($urandom);
      o_x = 6'($urandom); o_y = 5'($urandom); o_qs = 5'($urandom);
      v = o_mvv;
      if (v >= 16384) v = v - 32768;
      o_dh = o_mvh;
      o_dv = 16'(v);
      o_ds = 16'(64 * o_intra + o_pat);
      off_mb = 1'b1;
   endtask

   initial begin
      #(NE * 10 + 2000);
      $display("FAIL global_timeout edge=%0d got=running want=finished", n);
      $fatal(1, "timeout");
   end

   initial begin
      int t, r, nrand;
      reset = 1'b1; pic_valid = 1'b0; mb_valid = 1'b0; blk_rdy = 1'b1;
      pic_iframe = 1'b0; pic_qstype = 1'b0; pic_dcprec = 2'd0;
      mb_mv_en = 1'b0; mb_intra = 1'b0; mb_pattern = '0; mb_mv_h = '0;
      mb_mv_v = '0; mb_x = '0; mb_y = '0; mb_qscode = '0;
      n = 0; free_e = 2; rst_from = 0; rst_until = 2;
      checks = 0; errs = 0; acc_pic_e = 0; acc_mb_e = 0;
      off_pic = 1'b0; off_mb = 1'b0;
      o_pic = '0; o_dpic = '0; o_mven = 1'b0; o_intra = 1'b0; o_pat = '0;
      o_mvh = '0; o_mvv = '0; o_x = '0; o_y = '0; o_qs = '0;
      o_dh = '0; o_dv = '0; o_ds = '0;
      for (int i = 0; i < NE; i++) rdy[i] = 1'b1;

      //            pic  hdr   mv  in  pat    mvh       mvv       x   y   qs  e0        e1        e2
      tbl[0] = '{1'b1, 4'hA, 0, 0, 6'h00, 16'h0000, 15'h0000, 0,  0,  0,  16'h000A, 16'h0000, 16'h0000};
      tbl[1] = '{1'b1, 4'h7, 0, 0, 6'h00, 16'h0000, 15'h0000, 0,  0,  0,  16'h0007, 16'h0000, 16'h0000};
      tbl[2] = '{1'b0, 4'h0, 1, 0, 6'h15, 16'hFFFD, 15'h7FFE, 9,  3,  7,  16'hFFFD, 16'hFFFE, 16'h0015};
      tbl[3] = '{1'b0, 4'h0, 0, 1, 6'h3F, 16'h1234, 15'h0123, 5,  2,  1,  16'h0000, 16'h0000, 16'h007F};
      tbl[4] = '{1'b0, 4'h0, 1, 1, 6'h00, 16'h7FFF, 15'h3FFF, 17, 8,  12, 16'h7FFF, 16'h3FFF, 16'h0040};
      tbl[5] = '{1'b0, 4'h0, 1, 0, 6'h01, 16'h8000, 15'h4000, 63, 31, 31, 16'h8000, 16'hC000, 16'h0001};
      tbl[6] = '{1'b1, 4'hC, 0, 0, 6'h00, 16'h0000, 15'h0000, 0,  0,  0,  16'h000C, 16'h0000, 16'h0000};
      tbl[7] = '{1'b0, 4'h0, 0, 0, 6'h00, 16'h0000, 15'h0000, 0,  0,  0,  16'h0000, 16'h0000, 16'h0000};

      tick(); tick(); tick();

      for (int i = 0; i < 8; i++) begin
         load_vec(tbl[i]);
         if (tbl[i].is_pic) off_pic = 1'b1;
         else               off_mb  = 1'b1;
         wait_accept();
         drain();
      end

      // blk_rdy low for 10 cycles after the 3rd block_start of a no-MV MB.
      t = n + 2;
      for (int i = t + 11; i <= t + 20; i++) rdy[i] = 1'b0;
      load_vec(tbl[3]);
      off_mb = 1'b1;
      wait_accept();
      chk("stall_accept_edge", 32'(acc_mb_e), 32'(t));
      drain();

      // Picture and MB offered together: picture first, MB two edges later.
      load_vec(tbl[2]);
      o_pic = 4'hA; o_dpic = 16'h000A;
      off_pic = 1'b1; off_mb = 1'b1;
      wait_accept();
      chk("mb_after_pic", 32'(acc_mb_e - acc_pic_e), 32'd2);
      drain();

      // Reset sampled while in MVV aborts the sequence.
      load_vec(tbl[5]);
      off_mb = 1'b1;
      wait_accept();
      rst_from = acc_mb_e + 2; rst_until = acc_mb_e + 2;
      repeat (12) tick();
      chk("post_reset_busy", 32'(busy), 32'd0);
      drain();

      // Randomised traffic with a random blk_rdy schedule.
      for (int i = n + 2; i < NE; i++) rdy[i] = ($urandom_range(0, 2) != 0);
      nrand = 0;
      while (nrand < 100 && n < NE - 700) begin
         if (!off_pic && !off_mb && $urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 9);
            if (r < 3)      rand_pic();
            else if (r < 9) rand_mb();
            else begin rand_pic(); rand_mb(); end
            nrand++;
         end
         tick();
      end
      off_pic = 1'b0; off_mb = 1'b0;
      tick();
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
